// File: rtl/dsp_mult_bank.sv
// Multi-lane multiplier bank with a fixed-latency pipeline and per-lane accumulate.
// Products are formed at operand sample and carried through LATENCY-1 stages into dsp_out.
module dsp_mult_bank #(
  parameter int unsigned LANES   = 5,
  parameter int unsigned AW      = 18,
  parameter int unsigned BW      = 18,
  parameter int unsigned OW      = 37,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned SIGNED  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dsp_ce,
  input  logic [LANES*AW-1:0]   dsp_a0,
  input  logic [LANES*BW-1:0]   dsp_b0,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic [LANES*OW-1:0]   dsp_out,
  output logic                  out_valid,
  output logic                  busy
);

  // At least one stage is always declared so indexing stays legal when LATENCY=1.
  localparam int unsigned NS = (LATENCY > 1) ? LATENCY - 1 : 1;

  typedef logic [LANES*OW-1:0] lane_vec_t;

  lane_vec_t       prod_now;
  lane_vec_t       pipe_data_q [NS];
  lane_vec_t       pipe_data_d [NS];
  logic [NS-1:0]   pipe_vld_q, pipe_vld_d;
  logic [NS-1:0]   pipe_acc_q, pipe_acc_d;
  lane_vec_t       dsp_out_q, dsp_out_d;
  logic            out_valid_q, out_valid_d;
  logic            comp_vld, comp_acc;
  lane_vec_t       comp_prod;

  function automatic logic [OW-1:0] ext_a(input logic [AW-1:0] v);
    if (SIGNED != 0) return OW'($signed(v));
    else             return OW'(v);
  endfunction

  function automatic logic [OW-1:0] ext_b(input logic [BW-1:0] v);
    if (SIGNED != 0) return OW'($signed(v));
    else             return OW'(v);
  endfunction

  always_comb begin
    prod_now = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      prod_now[l*OW +: OW] = ext_a(dsp_a0[l*AW +: AW]) * ext_b(dsp_b0[l*BW +: BW]);
    end
  end

  // Data and acc flags only move with a valid token, so X operands on idle cycles stay out.
  always_comb begin
    pipe_vld_d  = pipe_vld_q;
    pipe_acc_d  = pipe_acc_q;
    pipe_data_d = pipe_data_q;
    pipe_vld_d[0] = dsp_ce;
    if (dsp_ce) begin
      pipe_acc_d[0]  = acc_en;
      pipe_data_d[0] = prod_now;
    end
    for (int unsigned s = 1; s < NS; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      if (pipe_vld_q[s-1]) begin
        pipe_acc_d[s]  = pipe_acc_q[s-1];
        pipe_data_d[s] = pipe_data_q[s-1];
      end
    end
  end

  always_comb begin
    if (LATENCY > 1) begin
      comp_vld  = pipe_vld_q[NS-1];
      comp_acc  = pipe_acc_q[NS-1];
      comp_prod = pipe_data_q[NS-1];
    end else begin
      comp_vld  = dsp_ce;
      comp_acc  = acc_en;
      comp_prod = prod_now;
    end
  end

  // acc_clr zeroes the running value before a same-cycle accumulate adds into it.
  always_comb begin
    dsp_out_d   = dsp_out_q;
    out_valid_d = comp_vld;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (comp_vld) begin
        if (comp_acc && !acc_clr)
          dsp_out_d[l*OW +: OW] = dsp_out_q[l*OW +: OW] + comp_prod[l*OW +: OW];
        else
          dsp_out_d[l*OW +: OW] = comp_prod[l*OW +: OW];
      end else if (acc_clr) begin
        dsp_out_d[l*OW +: OW] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld_q  <= '0;
      pipe_acc_q  <= '0;
      dsp_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_acc_q  <= pipe_acc_d;
      dsp_out_q   <= dsp_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    pipe_data_q <= pipe_data_d;
  end

  assign dsp_out   = dsp_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (LATENCY > 1) ? |pipe_vld_q : 1'b0;

endmodule

// File: tb/tb_dsp_mult_bank.sv
// Directed bench for dsp_mult_bank: three instances (LATENCY 1/3 unsigned, LATENCY 4 signed)
// share one stimulus bus; each scenario checks the instance it targets.
module tb_dsp_mult_bank;

  localparam int LANES = 5;
  localparam int AW    = 18;
  localparam int BW    = 18;
  localparam int OW    = 37;

  logic                clk;
  logic                rst_n;
  logic                dsp_ce;
  logic [LANES*AW-1:0] a0;
  logic [LANES*BW-1:0] b0;
  logic                acc_en;
  logic                acc_clr;

  logic [LANES*OW-1:0] out_l1, out_l3, out_l4;
  logic                ov_l1, ov_l3, ov_l4;
  logic                busy_l1, busy_l3, busy_l4;

  int checks;
  int failures;

  dsp_mult_bank #(.LANES(LANES), .AW(AW), .BW(BW), .OW(OW), .LATENCY(1), .SIGNED(0)) u_l1 (
    .clk(clk), .rst_n(rst_n), .dsp_ce(dsp_ce), .dsp_a0(a0), .dsp_b0(b0),
    .acc_en(acc_en), .acc_clr(acc_clr), .dsp_out(out_l1), .out_valid(ov_l1), .busy(busy_l1));

  dsp_mult_bank #(.LANES(LANES), .AW(AW), .BW(BW), .OW(OW), .LATENCY(3), .SIGNED(0)) u_l3 (
    .clk(clk), .rst_n(rst_n), .dsp_ce(dsp_ce), .dsp_a0(a0), .dsp_b0(b0),
    .acc_en(acc_en), .acc_clr(acc_clr), .dsp_out(out_l3), .out_valid(ov_l3), .busy(busy_l3));

  dsp_mult_bank #(.LANES(LANES), .AW(AW), .BW(BW), .OW(OW), .LATENCY(4), .SIGNED(1)) u_l4 (
    .clk(clk), .rst_n(rst_n), .dsp_ce(dsp_ce), .dsp_a0(a0), .dsp_b0(b0),
    .acc_en(acc_en), .acc_clr(acc_clr), .dsp_out(out_l4), .out_valid(ov_l4), .busy(busy_l4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [AW-1:0] a, input logic [BW-1:0] b);
    a0[l*AW +: AW] = a;
    b0[l*BW +: BW] = b;
  endtask

  function automatic logic [OW-1:0] lane(input logic [LANES*OW-1:0] v, input int l);
    return v[l*OW +: OW];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; dsp_ce = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    a0 = '0; b0 = '0;
    step(); step();
    checks++; if (out_l1 !== '0) begin failures++; $display("FAIL reset_out_l1 got=%h exp=0", out_l1); end
    checks++; if (out_l3 !== '0) begin failures++; $display("FAIL reset_out_l3 got=%h exp=0", out_l3); end
    checks++; if (out_l4 !== '0) begin failures++; $display("FAIL reset_out_l4 got=%h exp=0", out_l4); end
    checks++; if ({ov_l1, ov_l3, ov_l4} !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b exp=000", {ov_l1, ov_l3, ov_l4}); end
    checks++; if ({busy_l1, busy_l3, busy_l4} !== 3'b000) begin failures++; $display("FAIL reset_busy got=%b exp=000", {busy_l1, busy_l3, busy_l4}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_l1();
    a0 = '0; b0 = '0;
    set_lane(0, 18'd3, 18'd4);
    set_lane(4, 18'h3FFFF, 18'h3FFFF);
    dsp_ce = 1'b1; acc_en = 1'b0;
    step();
    checks++; if (ov_l1 !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", ov_l1); end
    checks++; if (lane(out_l1, 0) !== 37'd12) begin failures++; $display("FAIL single_lane0 got=%h exp=%h", lane(out_l1, 0), 37'd12); end
    checks++; if (lane(out_l1, 4) !== 37'h0FFFF80001) begin failures++; $display("FAIL single_lane4 got=%h exp=%h", lane(out_l1, 4), 37'h0FFFF80001); end
    checks++; if (busy_l1 !== 1'b0) begin failures++; $display("FAIL single_busy_l1 got=%b exp=0", busy_l1); end
    dsp_ce = 1'b0; a0 = 'x; b0 = 'x; acc_en = 1'bx;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (ov_l1 !== 1'b0) begin failures++; $display("FAIL hold_valid c=%0d got=%b exp=0", c, ov_l1); end
      checks++; if (lane(out_l1, 0) !== 37'd12) begin failures++; $display("FAIL hold_lane0 c=%0d got=%h exp=%h", c, lane(out_l1, 0), 37'd12); end
      checks++; if (lane(out_l1, 4) !== 37'h0FFFF80001) begin failures++; $display("FAIL hold_lane4 c=%0d got=%h exp=%h", c, lane(out_l1, 4), 37'h0FFFF80001); end
    end
    acc_en = 1'b0; a0 = '0; b0 = '0;
    step(); step();
  endtask

  task automatic test_back_to_back_l3();
    bit          iss  [9] = '{1, 1, 1, 0, 1, 0, 0, 0, 0};
    int          av   [9] = '{1, 2, 3, 0, 5, 0, 0, 0, 0};
    bit          vexp [9] = '{0, 0, 1, 1, 1, 0, 1, 0, 0};
    logic [36:0] res  [4] = '{37'd2, 37'd4, 37'd6, 37'd10};
    logic [36:0] exp_l0;
    bit          exp_busy;
    int          ridx;
    exp_l0 = 37'd12;  // lane 0 still holds 3*4 from the single-op scenario
    ridx = 0;
    acc_en = 1'b0; acc_clr = 1'b0;
    for (int c = 0; c < 9; c++) begin
      dsp_ce = iss[c];
      if (iss[c]) for (int l = 0; l < LANES; l++) set_lane(l, 18'(av[c]), 18'd2);
      step();
      if (vexp[c] && ridx < 4) begin exp_l0 = res[ridx]; ridx++; end
      exp_busy = iss[c] || (c >= 1 && iss[c-1]);
      checks++; if (ov_l3 !== vexp[c]) begin failures++; $display("FAIL b2b_valid edge=%0d got=%b exp=%b", c, ov_l3, vexp[c]); end
      checks++; if (lane(out_l3, 0) !== exp_l0) begin failures++; $display("FAIL b2b_lane0 edge=%0d got=%0d exp=%0d", c, lane(out_l3, 0), exp_l0); end
      checks++; if (busy_l3 !== exp_busy) begin failures++; $display("FAIL b2b_busy edge=%0d got=%b exp=%b", c, busy_l3, exp_busy); end
    end
    checks++; if (lane(out_l3, 3) !== 37'd10) begin failures++; $display("FAIL b2b_lane3 got=%0d exp=10", lane(out_l3, 3)); end
    dsp_ce = 1'b0;
  endtask

  task automatic test_signed_l4();
    a0 = '0; b0 = '0;
    set_lane(0, 18'h3FFFD, 18'd7);
    set_lane(1, 18'd5, 18'h3FFFE);
    dsp_ce = 1'b1; acc_en = 1'b0; acc_clr = 1'b0;
    step();
    dsp_ce = 1'b0;
    checks++; if (busy_l4 !== 1'b1) begin failures++; $display("FAIL signed_busy got=%b exp=1", busy_l4); end
    for (int c = 1; c < 6; c++) begin
      step();
      checks++; if (ov_l4 !== (c == 3)) begin failures++; $display("FAIL signed_valid edge=%0d got=%b exp=%b", c, ov_l4, (c == 3)); end
      if (c == 3) begin
        checks++; if (lane(out_l4, 0) !== 37'h1FFFFFFFEB) begin failures++; $display("FAIL signed_lane0 got=%h exp=%h", lane(out_l4, 0), 37'h1FFFFFFFEB); end
        checks++; if (lane(out_l4, 1) !== 37'h1FFFFFFFF6) begin failures++; $display("FAIL signed_lane1 got=%h exp=%h", lane(out_l4, 1), 37'h1FFFFFFFF6); end
      end
    end
  endtask

  task automatic test_accumulate_l1();
    acc_clr = 1'b1; dsp_ce = 1'b0;
    step();
    checks++; if (lane(out_l1, 0) !== 37'd0) begin failures++; $display("FAIL acc_clear got=%0d exp=0", lane(out_l1, 0)); end
    checks++; if (ov_l1 !== 1'b0) begin failures++; $display("FAIL acc_clear_valid got=%b exp=0", ov_l1); end
    acc_clr = 1'b0;
    set_lane(0, 18'd5, 18'd6);
    dsp_ce = 1'b1; acc_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (lane(out_l1, 0) !== 37'(30 * i)) begin failures++; $display("FAIL acc_sum i=%0d got=%0d exp=%0d", i, lane(out_l1, 0), 30 * i); end
      checks++; if (ov_l1 !== 1'b1) begin failures++; $display("FAIL acc_valid i=%0d got=%b exp=1", i, ov_l1); end
    end
    set_lane(0, 18'd1, 18'd1); acc_en = 1'b0;
    step();
    checks++; if (lane(out_l1, 0) !== 37'd1) begin failures++; $display("FAIL acc_overwrite got=%0d exp=1", lane(out_l1, 0)); end
    set_lane(0, 18'd2, 18'd2); acc_en = 1'b1; acc_clr = 1'b1;
    step();
    checks++; if (lane(out_l1, 0) !== 37'd4) begin failures++; $display("FAIL acc_clr_plus_add got=%0d exp=4", lane(out_l1, 0)); end
    checks++; if (ov_l1 !== 1'b1) begin failures++; $display("FAIL acc_clr_plus_add_valid got=%b exp=1", ov_l1); end
    dsp_ce = 1'b0; acc_clr = 1'b0; acc_en = 1'b0;
    step();
    checks++; if (ov_l1 !== 1'b0) begin failures++; $display("FAIL acc_idle_valid got=%b exp=0", ov_l1); end
    checks++; if (lane(out_l1, 0) !== 37'd4) begin failures++; $display("FAIL acc_idle_hold got=%0d exp=4", lane(out_l1, 0)); end
  endtask

  task automatic test_reset_midflight_l4();
    for (int c = 0; c < 5; c++) step();
    set_lane(0, 18'd7, 18'd7);
    dsp_ce = 1'b1; acc_en = 1'b0;
    step(); step();
    dsp_ce = 1'b0; rst_n = 1'b0;
    step();
    checks++; if (busy_l4 !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy_l4); end
    checks++; if (out_l4 !== '0) begin failures++; $display("FAIL midrst_out got=%h exp=0", out_l4); end
    checks++; if (ov_l4 !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", ov_l4); end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (ov_l4 !== 1'b0) begin failures++; $display("FAIL midrst_late_valid c=%0d got=%b exp=0", c, ov_l4); end
      checks++; if (lane(out_l4, 0) !== 37'd0) begin failures++; $display("FAIL midrst_late_out c=%0d got=%0d exp=0", c, lane(out_l4, 0)); end
      checks++; if (busy_l4 !== 1'b0) begin failures++; $display("FAIL midrst_late_busy c=%0d got=%b exp=0", c, busy_l4); end
    end
  endtask

  task automatic test_wrap_l1();
    logic [36:0] ref_sum;
    acc_clr = 1'b1; dsp_ce = 1'b0;
    step();
    acc_clr = 1'b0;
    set_lane(0, 18'h3FFFF, 18'h3FFFF);
    dsp_ce = 1'b1; acc_en = 1'b1;
    ref_sum = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      ref_sum = ref_sum + 37'h0FFFF80001;
      checks++; if (lane(out_l1, 0) !== ref_sum) begin failures++; $display("FAIL wrap_sum i=%0d got=%h exp=%h", i, lane(out_l1, 0), ref_sum); end
    end
    dsp_ce = 1'b0; acc_en = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_l1();
    test_back_to_back_l3();
    test_signed_l4();
    test_accumulate_l1();
    test_reset_midflight_l4();
    test_wrap_l1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsp_mult_bank.md
Name: dsp_mult_bank

Overview:
- Multi-lane multiplier responder on the DSP side of the convolution engine's operand/result interface.
- The engine drives operand pairs on dsp_a0/dsp_b0 and qualifies them with dsp_ce; this block returns lane products on dsp_out after a fixed pipeline latency.
- Optional per-lane accumulate mode for partial-sum reduction.
- Sits between matrix_convolution and the FPGA DSP slices, and is the synthesizable replacement for bench-level multiply models.

Parameters:
- LANES, 5, number of independent multiplier lanes.
- AW, 18, operand A width per lane.
- BW, 18, operand B width per lane.
- OW, 37, result width per lane; must be >= AW+BW.
- LATENCY, 1, register stages from operand sample to dsp_out; legal range 1..4.
- SIGNED, 0, 0 = unsigned operands, zero-extended; 1 = two's-complement operands, sign-extended to OW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous active-low.
- dsp_ce  input  1  operands valid this cycle.
- dsp_a0  input  LANES x AW  operand A per lane.
- dsp_b0  input  LANES x BW  operand B per lane.
- acc_en  input  1  sampled together with operands: 1 = add the product into the lane's dsp_out; 0 = overwrite dsp_out.
- acc_clr  input  1  clears all lane accumulators.
- dsp_out  output  LANES x OW  per-lane result register.
- out_valid  output  1  one-cycle pulse: dsp_out updated by a completed operation.
- busy  output  1  at least one operation is in flight in the pipeline.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - dsp_out all lanes = 0; out_valid = 0; busy = 0.
  - All pipeline valid flags and stored acc_en flags cleared; in-flight operations discarded.
  - Pipeline data registers need not be cleared.
  - Reset asserted mid-operation: no out_valid ever appears for operations sampled before reset.
- Issue and pipeline:
  - The pipeline advances every cycle; there is no stall and no backpressure.
  - At edge k with dsp_ce=1, all lanes' A, B and acc_en are sampled together.
  - The completed result is visible on dsp_out, with out_valid=1, immediately after edge k+LATENCY-1.
  - LATENCY=1: operands present before edge k appear on dsp_out after edge k.
  - dsp_ce=0 cycles inject bubbles; back-to-back dsp_ce gives one result per cycle, in issue order.
- Arithmetic:
  - Product = A*B, extended per SIGNED to OW bits, exact with no truncation.
  - Accumulate adds modulo 2^OW and wraps silently; there is no saturation.
- Output stage, per lane, applied at the edge where an operation completes:
  - acc_en=0: dsp_out <= product.
  - acc_en=1: dsp_out <= dsp_out + product.
- acc_clr, sampled at an edge, takes effect at that edge:
  - No completion that cycle: dsp_out <= 0.
  - Completion with acc_en=1 in the same cycle: dsp_out <= product (clear, then add).
  - Completion with acc_en=0 in the same cycle: dsp_out <= product.
  - acc_clr does not assert out_valid and does not affect in-flight operations.
- Hold: with no completion and no acc_clr, dsp_out holds its value indefinitely.
- out_valid: high for exactly one cycle per completed operation; low otherwise.
- busy: OR of the valid flags of all pipeline stages before the output register.
  - LATENCY=1: busy is constantly 0.
- Lanes are fully independent.
- X on operands while dsp_ce=0 must not propagate to dsp_out or out_valid.

Test Plan:
- Reset then single op, LATENCY=1, SIGNED=0:
  - Stimulus: lane0 A=3,B=4; lane4 A=18'h3FFFF,B=18'h3FFFF; dsp_ce=1 for one cycle.
  - Response: after the same edge, dsp_out[0]=12, dsp_out[4]=37'h0FFFF80001, out_valid=1 for one cycle; dsp_out holds afterwards.
- LATENCY=3, back-to-back issue with a bubble:
  - Stimulus: issue A=1..3 (B=2 on all lanes) on cycles 0,1,2, dsp_ce=0 on cycle 3, A=5 on cycle 4.
  - Response: out_valid high after edges 2,3,4,6; lane0 outputs 2,4,6,10 in order; busy low after edge 6.
- SIGNED=1:
  - Stimulus: A=-3 (18'h3FFFD), B=7.
  - Response: dsp_out = -21 sign-extended, i.e. 37'h1FFFFFFFEB.
- Accumulate:
  - Stimulus: acc_clr, then four ops with acc_en=1 (A=5,B=6 each), then one op with acc_en=0 (A=1,B=1); additionally acc_clr together with an acc_en=1 completion of 2*2.
  - Response: lane value 120, then 1; the combined clear-plus-completion case gives 4.
- Reset mid-flight:
  - Stimulus: LATENCY=4, issue two ops, assert rst_n=0 for one edge before the first completes.
  - Response: dsp_out=0, no out_valid pulse afterwards, busy=0 after the reset edge.
- Wrap:
  - Stimulus: accumulate 18'h3FFFF*18'h3FFFF, unsigned, repeatedly.
  - Response: sum wraps modulo 2^37 and matches a reference model each step.
